// File: rtl/wt_dcache_mem_sched_if.sv
// Request/response bundle between the write-through dcache front end, the
// memory scheduler and the memory side. Signal suffixes are from the scheduler's view.
interface wt_dcache_mem_sched_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned TidWidth  = 2
);
    localparam int unsigned BeWidth = DataWidth / 8;

    // Load-miss port
    logic                 ld_req_i;
    logic                 ld_gnt_o;
    logic [AddrWidth-1:0] ld_addr_i;

    // Write-buffer store port
    logic                 st_req_i;
    logic                 st_gnt_o;
    logic [AddrWidth-1:0] st_addr_i;
    logic [DataWidth-1:0] st_data_i;
    logic [BeWidth-1:0]   st_be_i;

    // Fence
    logic                 fence_i;
    logic                 fence_done_o;

    // Memory request
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic                 mem_store_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_data_o;
    logic [BeWidth-1:0]   mem_be_o;
    logic [TidWidth-1:0]  mem_tid_o;

    // Memory response
    logic                 mem_rtrn_vld_i;
    logic                 mem_rtrn_store_i;

    // Status
    logic [3:0]           st_outstanding_o;
    logic                 busy_o;

    // Scheduler side
    modport master (
        input  ld_req_i, ld_addr_i,
        input  st_req_i, st_addr_i, st_data_i, st_be_i,
        input  fence_i,
        input  mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_store_i,
        output ld_gnt_o, st_gnt_o, fence_done_o,
        output mem_req_o, mem_store_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
        output st_outstanding_o, busy_o
    );

    // Requesters and memory side
    modport slave (
        output ld_req_i, ld_addr_i,
        output st_req_i, st_addr_i, st_data_i, st_be_i,
        output fence_i,
        output mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_store_i,
        input  ld_gnt_o, st_gnt_o, fence_done_o,
        input  mem_req_o, mem_store_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
        input  st_outstanding_o, busy_o
    );
endinterface

// File: rtl/wt_dcache_mem_sched.sv
// Arbitrates load misses and write-buffer stores onto a single registered memory
// request port, tracks outstanding transactions and sequences fence drains.
module wt_dcache_mem_sched #(
    parameter int unsigned AddrWidth            = 64,
    parameter int unsigned DataWidth            = 64,
    parameter int unsigned TidWidth             = 2,
    parameter int unsigned MaxOutstandingStores = 7
) (
    input logic                  clk_i,
    input logic                  rst_i,
    wt_dcache_mem_sched_if.master bus
);
    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e               state_q, state_d;

    logic                 oreg_vld_q, oreg_vld_d;
    logic                 oreg_store_q, oreg_store_d;
    logic [AddrWidth-1:0] oreg_addr_q, oreg_addr_d;
    logic [DataWidth-1:0] oreg_data_q, oreg_data_d;
    logic [BeWidth-1:0]   oreg_be_q, oreg_be_d;
    logic [TidWidth-1:0]  oreg_tid_q, oreg_tid_d;

    logic                 load_pending_q, load_pending_d;
    logic                 last_store_q, last_store_d;
    logic [3:0]           st_cnt_q, st_cnt_d;
    logic [TidWidth-1:0]  seq_q, seq_d;

    logic                 oreg_free;
    logic                 idle;
    logic                 ld_elig, st_elig;
    logic                 ld_acc, st_acc;
    logic                 st_ack, ld_fill;

    // Arbitration and response qualification
    always_comb begin
        // Gated by rst_i so grants drop the same cycle reset is raised
        idle      = (state_q == StIdle) && !rst_i;
        oreg_free = !oreg_vld_q || bus.mem_gnt_i;
        ld_elig   = bus.ld_req_i && !load_pending_q && idle;
        st_elig   = bus.st_req_i && (st_cnt_q < 4'(MaxOutstandingStores)) && idle;
        ld_acc    = oreg_free && ld_elig && (!st_elig || last_store_q);
        st_acc    = oreg_free && st_elig && !ld_acc;
        // Acks with nothing to acknowledge are dropped to avoid underflow
        st_ack    = bus.mem_rtrn_vld_i && bus.mem_rtrn_store_i && (st_cnt_q != 4'd0);
        ld_fill   = bus.mem_rtrn_vld_i && !bus.mem_rtrn_store_i && load_pending_q;
    end

    // Output register, bookkeeping and fence FSM next state
    always_comb begin
        oreg_vld_d     = oreg_vld_q;
        oreg_store_d   = oreg_store_q;
        oreg_addr_d    = oreg_addr_q;
        oreg_data_d    = oreg_data_q;
        oreg_be_d      = oreg_be_q;
        oreg_tid_d     = oreg_tid_q;
        load_pending_d = load_pending_q;
        last_store_d   = last_store_q;
        st_cnt_d       = st_cnt_q;
        seq_d          = seq_q;
        state_d        = state_q;

        if (ld_acc) begin
            oreg_vld_d   = 1'b1;
            oreg_store_d = 1'b0;
            oreg_addr_d  = bus.ld_addr_i;
            oreg_data_d  = '0;
            oreg_be_d    = '0;
            oreg_tid_d   = '0;
        end else if (st_acc) begin
            oreg_vld_d   = 1'b1;
            oreg_store_d = 1'b1;
            oreg_addr_d  = bus.st_addr_i;
            oreg_data_d  = bus.st_data_i;
            oreg_be_d    = bus.st_be_i;
            oreg_tid_d   = seq_q;
        end else if (oreg_vld_q && bus.mem_gnt_i) begin
            oreg_vld_d   = 1'b0;
        end

        if (ld_acc) begin
            load_pending_d = 1'b1;
        end else if (ld_fill) begin
            load_pending_d = 1'b0;
        end

        if (ld_acc) begin
            last_store_d = 1'b0;
        end else if (st_acc) begin
            last_store_d = 1'b1;
        end

        unique case ({st_acc, st_ack})
            2'b10:   st_cnt_d = st_cnt_q + 4'd1;
            2'b01:   st_cnt_d = st_cnt_q - 4'd1;
            default: st_cnt_d = st_cnt_q;
        endcase

        if (st_acc) begin
            seq_d = seq_q + TidWidth'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.fence_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Look at next-state values so a same-cycle final ack completes the drain
                if (!oreg_vld_d && (st_cnt_d == 4'd0) && !load_pending_d) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            oreg_vld_q     <= 1'b0;
            oreg_store_q   <= 1'b0;
            oreg_addr_q    <= '0;
            oreg_data_q    <= '0;
            oreg_be_q      <= '0;
            oreg_tid_q     <= '0;
            load_pending_q <= 1'b0;
            last_store_q   <= 1'b1;
            st_cnt_q       <= 4'd0;
            seq_q          <= '0;
        end else begin
            state_q        <= state_d;
            oreg_vld_q     <= oreg_vld_d;
            oreg_store_q   <= oreg_store_d;
            oreg_addr_q    <= oreg_addr_d;
            oreg_data_q    <= oreg_data_d;
            oreg_be_q      <= oreg_be_d;
            oreg_tid_q     <= oreg_tid_d;
            load_pending_q <= load_pending_d;
            last_store_q   <= last_store_d;
            st_cnt_q       <= st_cnt_d;
            seq_q          <= seq_d;
        end
    end

    assign bus.ld_gnt_o         = ld_acc;
    assign bus.st_gnt_o         = st_acc;
    assign bus.fence_done_o     = (state_q == StDone);
    assign bus.mem_req_o        = oreg_vld_q;
    assign bus.mem_store_o      = oreg_store_q;
    assign bus.mem_addr_o       = oreg_addr_q;
    assign bus.mem_data_o       = oreg_data_q;
    assign bus.mem_be_o         = oreg_be_q;
    assign bus.mem_tid_o        = oreg_tid_q;
    assign bus.st_outstanding_o = st_cnt_q;
    assign bus.busy_o           = oreg_vld_q | load_pending_q | (st_cnt_q != 4'd0);

endmodule

// File: tb/tb_wt_dcache_mem_sched.sv
// Directed bench for the dcache memory scheduler: request payloads are checked
// against a scoreboard of expected requests, status outputs against constants.
module tb_wt_dcache_mem_sched;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 64;
    localparam int unsigned TW    = 2;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned MaxSt = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wt_dcache_mem_sched_if #(.AddrWidth(AW), .DataWidth(DW), .TidWidth(TW)) bus ();

    wt_dcache_mem_sched #(
        .AddrWidth           (AW),
        .DataWidth           (DW),
        .TidWidth            (TW),
        .MaxOutstandingStores(MaxSt)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    typedef struct packed {
        logic          store;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic [TW-1:0] tid;
    } req_t;

    req_t          sb[$];
    int            n_cmp;
    int            n_fail;
    logic [TW-1:0] tid_m;
    logic          cap_ld, cap_st, cap_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_ld(input logic [AW-1:0] a);
        req_t e;
        e.store = 1'b0; e.addr = a; e.data = '0; e.be = '0; e.tid = '0;
        sb.push_back(e);
    endtask

    task automatic exp_st(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_t e;
        e.store = 1'b1; e.addr = a; e.data = d; e.be = be; e.tid = tid_m;
        sb.push_back(e);
        tid_m = tid_m + 1'b1;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge
    task automatic step();
        req_t e;
        #1;
        cap_ld   = bus.ld_gnt_o;
        cap_st   = bus.st_gnt_o;
        cap_done = bus.fence_done_o;
        if (bus.mem_req_o && bus.mem_gnt_i) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("req_store", 64'(bus.mem_store_o), 64'(e.store));
                check("req_addr", bus.mem_addr_o, e.addr);
                check("req_data", bus.mem_data_o, e.data);
                check("req_be", 64'(bus.mem_be_o), 64'(e.be));
                check("req_tid", 64'(bus.mem_tid_o), 64'(e.tid));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ld_req_i = 1'b0; bus.ld_addr_i = '0;
        bus.st_req_i = 1'b0; bus.st_addr_i = '0; bus.st_data_i = '0; bus.st_be_i = '0;
        bus.fence_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.mem_rtrn_vld_i = 1'b0; bus.mem_rtrn_store_i = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        logic [3:0]    acks;
        n_cmp = 0; n_fail = 0; tid_m = '0;
        idle_inputs();
        rst = 1'b1;
        bus.ld_req_i = 1'b1; bus.st_req_i = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ld_gnt", 64'(bus.ld_gnt_o), 64'd0);
        check("rst_st_gnt", 64'(bus.st_gnt_o), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_cnt", 64'(bus.st_outstanding_o), 64'd0);
        check("rst_done", 64'(bus.fence_done_o), 64'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        // Alternating arbitration with a fill returned for each load
        bus.mem_gnt_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.ld_req_i = 1'b1; bus.st_req_i = 1'b1;
            bus.ld_addr_i = 64'h1000 + 64'(i) * 64'h40;
            bus.st_addr_i = 64'h2000 + 64'(i) * 64'h8;
            bus.st_data_i = {32'hdead_0000, 32'(i)};
            bus.st_be_i = 8'(i + 1);
            bus.mem_rtrn_vld_i = (i % 2 == 1); bus.mem_rtrn_store_i = 1'b0;
            if (i % 2 == 0) exp_ld(bus.ld_addr_i);
            else exp_st(bus.st_addr_i, bus.st_data_i, bus.st_be_i);
            step();
            check("alt_ld_gnt", 64'(cap_ld), 64'(i % 2 == 0));
            check("alt_st_gnt", 64'(cap_st), 64'(i % 2 == 1));
        end
        idle_inputs(); bus.mem_gnt_i = 1'b1;
        step();
        check("alt_cnt", 64'(bus.st_outstanding_o), 64'd5);
        check("alt_busy", 64'(bus.busy_o), 64'd1);
        bus.mem_rtrn_vld_i = 1'b1; bus.mem_rtrn_store_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle_inputs();
        check("alt_cnt_drained", 64'(bus.st_outstanding_o), 64'd0);
        check("alt_busy_drained", 64'(bus.busy_o), 64'd0);

        // Store limit: 8th store blocked until an ack frees a slot
        bus.mem_gnt_i = 1'b1; bus.st_req_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.st_addr_i = 64'h3000 + 64'(k) * 64'h8;
            bus.st_data_i = 64'h5555_0000_0000_0000 | 64'(k);
            bus.st_be_i = 8'hff;
            if (k < 7) exp_st(bus.st_addr_i, bus.st_data_i, bus.st_be_i);
            step();
            check("lim_st_gnt", 64'(cap_st), 64'(k < 7));
        end
        check("lim_cnt7", 64'(bus.st_outstanding_o), 64'd7);
        bus.mem_rtrn_vld_i = 1'b1; bus.mem_rtrn_store_i = 1'b1;
        step();
        check("lim_gnt_on_ack", 64'(cap_st), 64'd0);
        bus.mem_rtrn_vld_i = 1'b0;
        exp_st(bus.st_addr_i, bus.st_data_i, bus.st_be_i);
        step();
        check("lim_gnt_after_ack", 64'(cap_st), 64'd1);
        bus.st_req_i = 1'b0;
        step();
        check("lim_cnt7_again", 64'(bus.st_outstanding_o), 64'd7);
        bus.mem_rtrn_vld_i = 1'b1; bus.mem_rtrn_store_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("cnt4", 64'(bus.st_outstanding_o), 64'd4);
        // Simultaneous accept and ack
        bus.st_req_i = 1'b1; bus.st_addr_i = 64'h4000; bus.st_data_i = 64'h0123_4567_89ab_cdef;
        bus.st_be_i = 8'h0f;
        exp_st(bus.st_addr_i, bus.st_data_i, bus.st_be_i);
        step();
        check("sim_st_gnt", 64'(cap_st), 64'd1);
        check("sim_cnt4", 64'(bus.st_outstanding_o), 64'd4);
        bus.st_req_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("cnt0", 64'(bus.st_outstanding_o), 64'd0);
        step();
        check("spurious_ack_cnt", 64'(bus.st_outstanding_o), 64'd0);
        check("spurious_ack_busy", 64'(bus.busy_o), 64'd0);
        bus.mem_rtrn_store_i = 1'b0;
        step();
        check("spurious_fill_busy", 64'(bus.busy_o), 64'd0);
        idle_inputs();

        // Back-pressure: payload held while mem_gnt_i is low
        a = 64'hcafe_0000_1234_5678;
        bus.ld_req_i = 1'b1; bus.ld_addr_i = a;
        exp_ld(a);
        step();
        check("bp_ld_gnt", 64'(cap_ld), 64'd1);
        bus.st_req_i = 1'b1; bus.st_addr_i = 64'h9999; bus.ld_addr_i = 64'h7777;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_req", 64'(bus.mem_req_o), 64'd1);
            check("bp_addr", bus.mem_addr_o, a);
            check("bp_store", 64'(bus.mem_store_o), 64'd0);
            check("bp_no_gnt", 64'({cap_ld, cap_st}), 64'd0);
        end
        bus.ld_req_i = 1'b0; bus.st_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rtrn_vld_i = 1'b1; bus.mem_rtrn_store_i = 1'b0;
        step();
        idle_inputs();
        check("bp_busy_after", 64'(bus.busy_o), 64'd0);

        // Fence with three stores outstanding
        bus.mem_gnt_i = 1'b1; bus.st_req_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.st_addr_i = 64'h5000 + 64'(j) * 64'h8;
            bus.st_data_i = 64'(j) << 8;
            bus.st_be_i = 8'hf0;
            exp_st(bus.st_addr_i, bus.st_data_i, bus.st_be_i);
            step();
            check("fn_st_gnt", 64'(cap_st), 64'd1);
        end
        bus.st_req_i = 1'b0;
        step();
        bus.fence_i = 1'b1;
        step();
        check("fn_done_fence_cycle", 64'(cap_done), 64'd0);
        bus.fence_i = 1'b0; bus.ld_req_i = 1'b1; bus.st_req_i = 1'b1;
        acks = 4'b1011;
        for (int d2 = 0; d2 < 4; d2++) begin
            bus.mem_rtrn_vld_i = acks[d2]; bus.mem_rtrn_store_i = 1'b1;
            bus.fence_i = (d2 == 1);
            step();
            check("fn_drain_gnt", 64'({cap_ld, cap_st}), 64'd0);
            check("fn_drain_done", 64'(cap_done), 64'd0);
        end
        bus.mem_rtrn_vld_i = 1'b0; bus.fence_i = 1'b0;
        step();
        check("fn_done_pulse", 64'(cap_done), 64'd1);
        check("fn_done_gnt", 64'({cap_ld, cap_st}), 64'd0);
        bus.ld_req_i = 1'b0; bus.st_req_i = 1'b0;
        step();
        check("fn_done_cleared", 64'(cap_done), 64'd0);

        // Fence with nothing outstanding
        bus.fence_i = 1'b1;
        step();
        bus.fence_i = 1'b0;
        step();
        check("fe_drain_done", 64'(cap_done), 64'd0);
        step();
        check("fe_done_pulse", 64'(cap_done), 64'd1);
        step();
        check("fe_done_cleared", 64'(cap_done), 64'd0);

        // Reset with a load pending and the output register full
        bus.mem_gnt_i = 1'b0; bus.ld_req_i = 1'b1; bus.ld_addr_i = 64'hbeef_0000;
        exp_ld(bus.ld_addr_i);
        step();
        check("rs_ld_gnt", 64'(cap_ld), 64'd1);
        bus.st_req_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rs_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rs_addr", bus.mem_addr_o, 64'd0);
        check("rs_store", 64'(bus.mem_store_o), 64'd0);
        check("rs_gnt", 64'({bus.ld_gnt_o, bus.st_gnt_o}), 64'd0);
        check("rs_busy", 64'(bus.busy_o), 64'd0);
        check("rs_cnt", 64'(bus.st_outstanding_o), 64'd0);
        sb.delete();
        tid_m = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_gnt_i = 1'b1; bus.ld_addr_i = 64'hbeef_1000;
        exp_ld(bus.ld_addr_i);
        step();
        check("rs_ld_first", 64'(cap_ld), 64'd1);
        check("rs_st_first", 64'(cap_st), 64'd0);
        bus.ld_req_i = 1'b0;
        a = 64'h6000; d = 64'hfeed_face; be = 8'h3c;
        bus.st_addr_i = a; bus.st_data_i = d; bus.st_be_i = be;
        exp_st(a, d, be);
        step();
        check("rs_st_tid0_gnt", 64'(cap_st), 64'd1);
        bus.st_req_i = 1'b0;
        step();
        bus.mem_rtrn_vld_i = 1'b1; bus.mem_rtrn_store_i = 1'b0;
        step();
        bus.mem_rtrn_store_i = 1'b1;
        step();
        idle_inputs();
        check("end_busy", 64'(bus.busy_o), 64'd0);
        check("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
